st_native_x2x_ser: RTL and testbench



---
 rtl/st_native_x2x_ser_if.sv | 20 ++
 rtl/st_native_x2x_ser.sv | 91 +++++++++
 tb/tb_st_native_x2x_ser.sv | 132 +++++++++++++
 3 files changed

// File: rtl/st_native_x2x_ser_if.sv
// st_native_x2x_ser_if: value-in / store-beat-out handshake bundle
interface st_native_x2x_ser_if;
    logic        in_vld;
    logic        in_rdy;
    logic [80:0] in_data;
    logic        out_vld;
    logic        out_rdy;
    logic [63:0] out_data;
    logic [7:0]  out_be;
    logic        out_last;
    logic [2:0]  out_flags;
    modport slave (
        input  in_vld, in_data, out_rdy,
        output in_rdy, out_vld, out_data, out_be, out_last, out_flags
    );
    modport master (
        output in_vld, in_data, out_rdy,
        input  in_rdy, out_vld, out_data, out_be, out_last, out_flags
    );
endinterface

// File: rtl/st_native_x2x_ser.sv
// st_native_x2x_ser: native extended to x87 80-bit format, serialized as two store beats
module st_native_x2x_ser (
    input logic clk,
    input logic rst,
    st_native_x2x_ser_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;
    state_t      state_q;
    logic        vld_q, last_q;
    logic [63:0] data_q;
    logic [7:0]  be_q;
    logic [2:0]  flags_q;
    logic [15:0] hi_q;
    logic        sgn;
    logic [15:0] e, s, xn;
    logic [63:0] m, mant_d;
    logic [127:0] crs, fin;
    logic        big;
    logic [15:0] hi_d;
    logic [2:0]  flags_d;
    logic        acc;
    // decode the native value and convert it; denormals shift right by 8-bit then 1-bit steps
    always_comb begin
        sgn     = bus.in_data[80];
        e       = {bus.in_data[79], bus.in_data[64], bus.in_data[78:65]};
        m       = bus.in_data[63:0];
        s       = 16'h4001 - e;
        xn      = e - 16'h4000;
        crs     = {m, 64'b0} >> {s[5:3], 3'b000};
        fin     = crs >> s[2:0];
        big     = |s[15:6];
        mant_d  = m;
        hi_d    = {sgn, xn[14:0]};
        flags_d = 3'b000;
        if (e == 16'h0000) begin
            mant_d  = 64'b0;
            hi_d    = {sgn, 15'h0000};
            flags_d = (|m) ? 3'b011 : 3'b000;
        end else if (e <= 16'h4000) begin
            mant_d  = big ? 64'b0 : fin[127:64];
            hi_d    = {sgn, 15'h0000};
            flags_d = {1'b0, (mant_d != m) | (|m), big ? |m : |fin[63:0]};
        end else if (e >= 16'hBFFF && e != 16'hFFFF) begin
            mant_d  = 64'h8000_0000_0000_0000;
            hi_d    = {sgn, 15'h7FFF};
            flags_d = 3'b101;
        end else if (e == 16'hFFFF) begin
            mant_d  = {1'b1, m[62:0]};
            hi_d    = {sgn, 15'h7FFF};
        end
    end
    assign bus.in_rdy    = !rst && (state_q == IDLE || (state_q == BEAT1 && bus.out_rdy));
    assign acc           = bus.in_vld && bus.in_rdy;
    assign bus.out_vld   = vld_q;
    assign bus.out_data  = data_q;
    assign bus.out_be    = be_q;
    assign bus.out_last  = last_q;
    assign bus.out_flags = flags_q;
    // beat sequencer: capture on acceptance, mantissa beat then sign/exponent beat
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vld_q   <= 1'b0;
            data_q  <= 64'b0;
            be_q    <= 8'h00;
            last_q  <= 1'b0;
            flags_q <= 3'b000;
            hi_q    <= 16'h0000;
        end else if (acc) begin
            state_q <= BEAT0;
            vld_q   <= 1'b1;
            data_q  <= mant_d;
            be_q    <= 8'hFF;
            last_q  <= 1'b0;
            flags_q <= flags_d;
            hi_q    <= hi_d;
        end else if (state_q == BEAT0 && bus.out_rdy) begin
            state_q <= BEAT1;
            data_q  <= {48'b0, hi_q};
            be_q    <= 8'h03;
            last_q  <= 1'b1;
        end else if (state_q == BEAT1 && bus.out_rdy) begin
            state_q <= IDLE;
            vld_q   <= 1'b0;
            data_q  <= 64'b0;
            be_q    <= 8'h00;
            last_q  <= 1'b0;
            flags_q <= 3'b000;
        end
    end
endmodule

// File: tb/tb_st_native_x2x_ser.sv
// tb_st_native_x2x_ser: table-driven conversion vectors plus handshake corner sequences
module tb_st_native_x2x_ser;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int fails = 0;
    st_native_x2x_ser_if bus();
    st_native_x2x_ser dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    typedef struct {
        logic [80:0] a;
        logic [63:0] b0;
        logic [15:0] b1;
        logic [2:0]  fl;
    } vec_t;
    vec_t vt[14];
    function automatic logic [80:0] mk(input logic s, input logic [15:0] e, input logic [63:0] m);
        return {s, e[15], e[13:0], e[14], m};
    endfunction
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask
    task automatic beat(input string nm, input logic [63:0] d, input logic [7:0] be, input logic last, input logic [2:0] fl);
        chk({nm, ".vld"}, {63'b0, bus.out_vld}, 64'd1);
        chk({nm, ".data"}, bus.out_data, d);
        chk({nm, ".be"}, {56'b0, bus.out_be}, {56'b0, be});
        chk({nm, ".last"}, {63'b0, bus.out_last}, {63'b0, last});
        chk({nm, ".flags"}, {61'b0, bus.out_flags}, {61'b0, fl});
    endtask
    initial begin
        vt[0]  = '{mk(0, 16'h7FFF, 64'h8000_0000_0000_0000), 64'h8000_0000_0000_0000, 16'h3FFF, 3'b000};
        vt[1]  = '{mk(0, 16'h3FFF, 64'h8000_0000_0000_0001), 64'h2000_0000_0000_0000, 16'h0000, 3'b011};
        vt[2]  = '{mk(1, 16'hC000, 64'h1234_5678_9ABC_DEF0), 64'h8000_0000_0000_0000, 16'hFFFF, 3'b101};
        vt[3]  = '{mk(0, 16'hFFFF, 64'h0000_0000_0000_0001), 64'h8000_0000_0000_0001, 16'h7FFF, 3'b000};
        vt[4]  = '{mk(1, 16'h0000, 64'h0), 64'h0, 16'h8000, 3'b000};
        vt[5]  = '{mk(0, 16'h0000, 64'h5), 64'h0, 16'h0000, 3'b011};
        vt[6]  = '{mk(0, 16'h3FC1, 64'h8000_0000_0000_0000), 64'h0, 16'h0000, 3'b011};
        vt[7]  = '{mk(0, 16'h4000, 64'h8000_0000_0000_0000), 64'h4000_0000_0000_0000, 16'h0000, 3'b010};
        vt[8]  = '{mk(0, 16'h4001, 64'hC000_0000_0000_0000), 64'hC000_0000_0000_0000, 16'h0001, 3'b000};
        vt[9]  = '{mk(1, 16'hBFFE, 64'h8000_0000_0000_0003), 64'h8000_0000_0000_0003, 16'hFFFE, 3'b000};
        vt[10] = '{mk(0, 16'hBFFF, 64'hFFFF_FFFF_FFFF_FFFF), 64'h8000_0000_0000_0000, 16'h7FFF, 3'b101};
        vt[11] = '{mk(0, 16'h3FF9, 64'h0123_4567_89AB_CDEF), 64'h0001_2345_6789_ABCD, 16'h0000, 3'b011};
        vt[12] = '{mk(0, 16'h3FF8, 64'hFF00_0000_0000_0100), 64'h007F_8000_0000_0000, 16'h0000, 3'b011};
        vt[13] = '{mk(1, 16'h0001, 64'h0), 64'h0, 16'h8000, 3'b000};
        bus.in_vld  = 1'b0;
        bus.in_data = '0;
        bus.out_rdy = 1'b1;
        @(negedge clk);
        chk("rst.in_rdy", {63'b0, bus.in_rdy}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst.vld", {63'b0, bus.out_vld}, 64'd0);
        chk("rst.data", bus.out_data, 64'd0);
        chk("rst.be", {56'b0, bus.out_be}, 64'd0);
        chk("rst.last", {63'b0, bus.out_last}, 64'd0);
        chk("rst.flags", {61'b0, bus.out_flags}, 64'd0);
        chk("rst.in_rdy_after", {63'b0, bus.in_rdy}, 64'd1);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            bus.in_vld  = 1'b1;
            bus.in_data = vt[i].a;
            bus.out_rdy = 1'b1;
            #1 chk($sformatf("v%0d.idle_rdy", i), {63'b0, bus.in_rdy}, 64'd1);
            @(negedge clk);
            beat($sformatf("v%0d.b0", i), vt[i].b0, 8'hFF, 1'b0, vt[i].fl);
            chk($sformatf("v%0d.b0_rdy", i), {63'b0, bus.in_rdy}, 64'd0);
            bus.in_vld = 1'b0;
            @(negedge clk);
            beat($sformatf("v%0d.b1", i), {48'b0, vt[i].b1}, 8'h03, 1'b1, vt[i].fl);
            chk($sformatf("v%0d.b1_rdy", i), {63'b0, bus.in_rdy}, 64'd1);
            @(negedge clk);
            chk($sformatf("v%0d.idle_vld", i), {63'b0, bus.out_vld}, 64'd0);
        end
        @(negedge clk);
        bus.in_vld  = 1'b1;
        bus.in_data = vt[0].a;
        @(negedge clk);
        beat("b2b.v0b0", vt[0].b0, 8'hFF, 1'b0, vt[0].fl);
        chk("b2b.b0_rdy", {63'b0, bus.in_rdy}, 64'd0);
        bus.in_data = vt[3].a;
        @(negedge clk);
        beat("b2b.v0b1", {48'b0, vt[0].b1}, 8'h03, 1'b1, vt[0].fl);
        chk("b2b.b1_rdy", {63'b0, bus.in_rdy}, 64'd1);
        bus.in_data = vt[2].a;
        @(negedge clk);
        beat("b2b.v2b0", vt[2].b0, 8'hFF, 1'b0, vt[2].fl);
        bus.in_vld = 1'b0;
        @(negedge clk);
        beat("b2b.v2b1", {48'b0, vt[2].b1}, 8'h03, 1'b1, vt[2].fl);
        @(negedge clk);
        chk("b2b.idle", {63'b0, bus.out_vld}, 64'd0);
        bus.in_vld  = 1'b1;
        bus.in_data = vt[1].a;
        bus.out_rdy = 1'b0;
        @(negedge clk);
        bus.in_vld  = 1'b0;
        bus.in_data = vt[10].a;
        for (int k = 0; k < 5; k++) begin
            beat($sformatf("bp.hold%0d", k), vt[1].b0, 8'hFF, 1'b0, vt[1].fl);
            chk($sformatf("bp.rdy%0d", k), {63'b0, bus.in_rdy}, 64'd0);
            @(negedge clk);
        end
        bus.out_rdy = 1'b1;
        @(negedge clk);
        beat("bp.b1", {48'b0, vt[1].b1}, 8'h03, 1'b1, vt[1].fl);
        bus.out_rdy = 1'b0;
        bus.in_vld  = 1'b1;
        #1 chk("bp.b1_stall_rdy", {63'b0, bus.in_rdy}, 64'd0);
        @(negedge clk);
        beat("bp.b1_hold", {48'b0, vt[1].b1}, 8'h03, 1'b1, vt[1].fl);
        rst = 1'b1;
        bus.out_rdy = 1'b1;
        #1 chk("rb1.rst_rdy", {63'b0, bus.in_rdy}, 64'd0);
        @(negedge clk);
        chk("rb1.vld", {63'b0, bus.out_vld}, 64'd0);
        chk("rb1.flags", {61'b0, bus.out_flags}, 64'd0);
        bus.in_vld = 1'b0;
        rst = 1'b0;
        #1 chk("rb1.rdy_after", {63'b0, bus.in_rdy}, 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rb1.no_stale%0d", k), {63'b0, bus.out_vld}, 64'd0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
